// File: rtl/fw_pkg.sv
// Shared definitions for the Floyd-Warshall tile engine.
// Holds the tile geometry constants, the phase and FSM state enums and the
// small helpers used by the datapath: word <-> row/column mapping for the
// 64-bit stream packing, and the saturating distance adder.
package fw_pkg;

  localparam int N     = 8;              // tile dimension
  localparam int W     = 16;             // distance width
  localparam int LANES = 4;              // distances per stream word
  localparam int WORDS = N * N / LANES;  // stream words per tile

  localparam logic [W-1:0] INF = {W{1'b1}};

  typedef enum logic [1:0] {
    PH_A = 2'b00,  // self-dependent tile
    PH_B = 2'b01,  // row-dependent tile
    PH_C = 2'b10,  // column-dependent tile
    PH_D = 2'b11   // doubly-dependent tile
  } phase_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    COMP = 2'b10,
    OUT  = 2'b11
  } fsm_t;

  // Row-major packing: two words per row, lane 0 holds the lowest column.
  function automatic logic [2:0] word_row(input logic [3:0] w);
    return w[3:1];
  endfunction

  function automatic logic [2:0] word_col(input logic [3:0] w, input logic [1:0] lane);
    return {w[0], lane};
  endfunction

  // Infinity is absorbing and any carry out clamps to infinity, so a
  // path can never wrap around into a spuriously short distance.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if ((a == INF) || (b == INF) || s[W]) begin
      return INF;
    end
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/fw_minplus_cell.sv
// One min-plus relaxation cell.
//   t : current distance of this cell
//   a : left operand  (distance i -> k)
//   b : right operand (distance k -> j)
//   y : min(t, a + b) with saturating add; a tie keeps t
module fw_minplus_cell
  import fw_pkg::*;
(
  input  logic [W-1:0] t,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W-1:0] s;

  assign s = sat_add(a, b);
  assign y = (s < t) ? s : t;

endmodule

// File: rtl/fw_unit.sv
// Blocked Floyd-Warshall min-plus engine for one 8x8 tile of 16-bit distances.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   phase     : tile kind (A self, B row, C column, D doubly dependent),
//               sampled with the first accepted word of a job
//   in_valid  : inD holds a word; accepted only while inhibit is low
//   inD       : input word, lane L = bits[16L+15:16L]
//   inhibit   : high while computing / streaming out; input is dropped
//   out_valid : outD holds a result word
//   outD      : result word (zero when out_valid is low)
// Streams: A = T; B/C = P,T; D = R,C,T (16 words each). R shares the P
// storage since no phase needs both.
module fw_unit
  import fw_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  phase,
  input  logic        in_valid,
  input  logic [63:0] inD,
  output logic        inhibit,
  output logic        out_valid,
  output logic [63:0] outD
);

  // Tile storage (no reset needed: always fully loaded before use)
  logic [W-1:0] p_q [N][N];
  logic [W-1:0] p_d [N][N];
  logic [W-1:0] c_q [N][N];
  logic [W-1:0] c_d [N][N];
  logic [W-1:0] t_q [N][N];
  logic [W-1:0] t_d [N][N];

  logic [N*N-1:0][W-1:0] cell_y;

  fsm_t        state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [5:0]  cnt_q, cnt_d;   // word index in LOAD, k in COMP, word in OUT

  logic        accept;
  phase_t      ld_phase;
  logic [5:0]  last_word;
  logic [3:0]  wsel;
  logic [1:0]  region;
  logic        to_p, to_c, to_t;
  logic [2:0]  k;

  assign accept = in_valid && ((state_q == IDLE) || (state_q == LOAD));
  // The very first word of a job is routed using the live phase input.
  assign ld_phase = (state_q == IDLE) ? phase_t'(phase) : phase_q;
  assign wsel     = cnt_q[3:0];
  assign region   = cnt_q[5:4];
  assign k        = cnt_q[2:0];

  always_comb begin
    last_word = 6'd15;
    to_p      = 1'b0;
    to_c      = 1'b0;
    to_t      = 1'b0;
    unique case (ld_phase)
      PH_A: begin
        last_word = 6'd15;
        to_t      = 1'b1;
      end
      PH_B, PH_C: begin
        last_word = 6'd31;
        to_p      = (region == 2'd0);
        to_t      = (region == 2'd1);
      end
      PH_D: begin
        last_word = 6'd47;
        to_p      = (region == 2'd0);
        to_c      = (region == 2'd1);
        to_t      = (region == 2'd2);
      end
    endcase
  end

  // Relaxation array: every cell reads the T values from the previous k.
  genvar gi;
  generate
    for (gi = 0; gi < N * N; gi++) begin : g_cell
      localparam int I = gi / N;
      localparam int J = gi % N;
      logic [W-1:0] op_a;
      logic [W-1:0] op_b;

      always_comb begin
        op_a = t_q[I][k];
        op_b = t_q[k][J];
        unique case (phase_q)
          PH_A: begin op_a = t_q[I][k]; op_b = t_q[k][J]; end
          PH_B: begin op_a = p_q[I][k]; op_b = t_q[k][J]; end
          PH_C: begin op_a = t_q[I][k]; op_b = p_q[k][J]; end
          PH_D: begin op_a = c_q[I][k]; op_b = p_q[k][J]; end
        endcase
      end

      fw_minplus_cell u_cell (
        .t (t_q[I][J]),
        .a (op_a),
        .b (op_b),
        .y (cell_y[gi])
      );
    end
  endgenerate

  always_comb begin
    p_d = p_q;
    c_d = c_q;
    t_d = t_q;
    if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (to_p) p_d[word_row(wsel)][word_col(wsel, 2'(l))] = inD[16*l +: 16];
        if (to_c) c_d[word_row(wsel)][word_col(wsel, 2'(l))] = inD[16*l +: 16];
        if (to_t) t_d[word_row(wsel)][word_col(wsel, 2'(l))] = inD[16*l +: 16];
      end
    end
    if (state_q == COMP) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          t_d[i][j] = cell_y[i*N + j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
    c_q <= c_d;
    t_q <= t_d;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          phase_d = phase_t'(phase);
          state_d = LOAD;
          cnt_d   = 6'd1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == last_word) begin
            state_d = COMP;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      COMP: begin
        if (cnt_q[2:0] == 3'(N - 1)) begin
          state_d = OUT;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      OUT: begin
        if (cnt_q[3:0] == 4'(WORDS - 1)) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= PH_A;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign inhibit   = (state_q == COMP) || (state_q == OUT);
  assign out_valid = (state_q == OUT);

  always_comb begin
    outD = '0;
    if (out_valid) begin
      for (int l = 0; l < LANES; l++) begin
        outD[16*l +: 16] = t_q[word_row(wsel)][word_col(wsel, 2'(l))];
      end
    end
  end

endmodule

// File: tb/tb_fw_unit.sv
module tb_fw_unit;

  localparam logic [15:0] INF = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic [1:0]  phase;
  logic        in_valid;
  logic [63:0] inD;
  logic        inhibit;
  logic        out_valid;
  logic [63:0] outD;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_p   [8][8];
  logic [15:0] m_c   [8][8];
  logic [15:0] m_t   [8][8];
  logic [15:0] exp_t [8][8];

  fw_unit dut (
    .clk       (clk),
    .reset     (reset),
    .phase     (phase),
    .in_valid  (in_valid),
    .inD       (inD),
    .inhibit   (inhibit),
    .out_valid (out_valid),
    .outD      (outD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // sel: 0 = P/R, 1 = C, 2 = T, 3 = expected T
  function automatic logic [63:0] get_word(input int sel, input int w);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      case (sel)
        0:       r[16*l +: 16] = m_p[w/2][4*(w%2)+l];
        1:       r[16*l +: 16] = m_c[w/2][4*(w%2)+l];
        2:       r[16*l +: 16] = m_t[w/2][4*(w%2)+l];
        default: r[16*l +: 16] = exp_t[w/2][4*(w%2)+l];
      endcase
    end
    return r;
  endfunction

  function automatic logic [15:0] sadd(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (a == INF || b == INF || s[16]) return INF;
    return s[15:0];
  endfunction

  // Software Floyd-Warshall step model: each k uses the tile from step k-1.
  task automatic model(input logic [1:0] ph);
    logic [15:0] prev [8][8];
    logic [15:0] a, b, s;
    exp_t = m_t;
    for (int k = 0; k < 8; k++) begin
      prev = exp_t;
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          case (ph)
            2'd0:    begin a = prev[i][k]; b = prev[k][j]; end
            2'd1:    begin a = m_p[i][k];  b = prev[k][j]; end
            2'd2:    begin a = prev[i][k]; b = m_p[k][j];  end
            default: begin a = m_c[i][k];  b = m_p[k][j];  end
          endcase
          s = sadd(a, b);
          if (s < prev[i][j]) exp_t[i][j] = s;
        end
      end
    end
  endtask

  task automatic fill_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m_p[i][j] = v;
        m_c[i][j] = v;
        m_t[i][j] = v;
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m_p[i][j] = 16'($urandom_range(0, 100));
        m_c[i][j] = 16'($urandom_range(0, 100));
        m_t[i][j] = 16'($urandom_range(0, 100));
      end
    end
  endtask

  // Inputs change on the falling edge and are captured on the next rising edge.
  task automatic step(input logic v, input logic [63:0] d);
    in_valid = v;
    inD      = d;
    @(negedge clk);
  endtask

  // Streams a job; stop_after < total words leaves a partial load behind.
  task automatic send_job(input logic [1:0] ph, input bit gaps, input int stop_after);
    int seq [3];
    int ntiles;
    int sent;
    sent = 0;
    seq  = '{0, 1, 2};
    case (ph)
      2'd0:       begin ntiles = 1; seq[0] = 2; end
      2'd1, 2'd2: begin ntiles = 2; seq[0] = 0; seq[1] = 2; end
      default:    ntiles = 3;
    endcase
    phase = ph;
    for (int t = 0; t < ntiles; t++) begin
      for (int w = 0; w < 16; w++) begin
        if (sent < stop_after) begin
          if (gaps && (sent % 3 == 2)) step(1'b0, {$urandom, $urandom});
          step(1'b1, get_word(seq[t], w));
          sent++;
          // A later phase change must not affect the job in flight.
          if (gaps && sent == 1) phase = ~ph;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Called one cycle after the last accepted word (first COMP cycle).
  // abort_s < 24 pulls reset at that point of the window instead of finishing.
  task automatic run_window(input string tag, input bit inject, input int abort_s);
    logic [63:0] exp_d;
    for (int s = 0; s < 24; s++) begin
      if (s == abort_s) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s rst_flags", tag), {62'd0, inhibit, out_valid}, 64'd0);
        check($sformatf("%s rst_outD", tag), outD, 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        $display("job %s: reset applied at window cycle %0d", tag, s);
        return;
      end
      exp_d = (s >= 8) ? get_word(3, s - 8) : 64'd0;
      check($sformatf("%s flags%0d", tag, s), {62'd0, inhibit, out_valid},
            {62'd0, 1'b1, (s >= 8)});
      check($sformatf("%s outD%0d", tag, s), outD, exp_d);
      step(inject && (s % 5 == 1), {$urandom, $urandom});
    end
    in_valid = 1'b0;
    check($sformatf("%s flags_end", tag), {62'd0, inhibit, out_valid}, 64'd0);
    check($sformatf("%s outD_end", tag), outD, 64'd0);
    $display("job %s: 16 result words checked", tag);
  endtask

  task automatic setup_t1();
    fill_all(INF);
    for (int i = 0; i < 8; i++) m_t[i][i] = 16'h0000;
    m_t[0][1] = 16'd3;
    m_t[1][2] = 16'd4;
    m_t[2][3] = 16'd5;
    exp_t = m_t;
    exp_t[0][2] = 16'd7;
    exp_t[0][3] = 16'd12;
    exp_t[1][3] = 16'd9;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    inD      = '0;
    phase    = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_flags", {62'd0, inhibit, out_valid}, 64'd0);
    check("reset_outD", outD, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: phase A shortest paths through a short chain
    setup_t1();
    send_job(2'd0, 1'b0, 99);
    run_window("t1_A", 1'b0, 24);

    // 2: phase C, zero pivot tile collapses row 0 to its minimum (0)
    fill_all(INF);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_p[i][j] = 16'h0000;
    m_t[0] = '{16'h4e, 16'h57, 16'h54, 16'h00, 16'h57, 16'h24, 16'h5e, 16'h10};
    exp_t = m_t;
    for (int j = 0; j < 8; j++) exp_t[0][j] = 16'h0000;
    send_job(2'd2, 1'b0, 99);
    run_window("t2_C", 1'b0, 24);

    // 3a: phase B with overflowing and infinite sums
    fill_all(INF);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_t[i][j] = 16'h9000;
    for (int j = 0; j < 8; j++) begin
      m_t[0][j] = 16'h0100;
      m_t[5][j] = INF;
    end
    m_p[0][0] = 16'h7FFF;
    m_p[2][0] = 16'h0010;
    m_p[3][1] = 16'h7FFF;
    m_p[6][5] = 16'h0002;
    exp_t = m_t;
    for (int j = 0; j < 8; j++) exp_t[2][j] = 16'h0110;
    send_job(2'd1, 1'b0, 99);
    run_window("t3_B", 1'b0, 24);

    // 3b + 4: phase D, 7FFF+9000 must not wrap; gapped input, words during inhibit
    fill_all(INF);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_t[i][j] = 16'h1000;
    for (int j = 0; j < 8; j++) m_p[0][j] = 16'h9000;
    m_p[2][3] = 16'd7;
    m_c[0][0] = 16'h7FFF;
    m_c[1][2] = 16'd5;
    exp_t = m_t;
    exp_t[1][3] = 16'h000C;
    send_job(2'd3, 1'b1, 99);
    run_window("t4_D_gaps", 1'b1, 24);

    // 5a: reset in the middle of a load, then a fresh phase A job
    fill_random();
    send_job(2'd3, 1'b0, 10);
    reset = 1'b0;
    #1;
    check("t5_load_rst_flags", {62'd0, inhibit, out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    setup_t1();
    send_job(2'd0, 1'b0, 99);
    run_window("t5_after_load_rst", 1'b0, 24);

    // 5b: reset in the middle of output, then a fresh phase A job
    send_job(2'd0, 1'b0, 99);
    run_window("t5_out_abort", 1'b0, 12);
    @(negedge clk);
    check("t5_idle_after_rst", {62'd0, inhibit, out_valid}, 64'd0);
    send_job(2'd0, 1'b0, 99);
    run_window("t5_after_out_rst", 1'b0, 24);

    // 6: back-to-back random jobs, each starting the cycle inhibit drops
    for (int n = 0; n < 4; n++) begin
      fill_random();
      model(2'(n));
      send_job(2'(n), 1'b0, 99);
      run_window($sformatf("t6_rand%0d", n), 1'b0, 24);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
